// File: rtl/spi_top_core.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | spi_top_core - Wishbone-slave SPI master, 1..SPI_MAX_CHAR bits per GO   |
// | Rev 1.0                                                                 |
// +------------------------------------------------------------------------+
module spi_top_core #(
  parameter int SPI_MAX_CHAR    = 128,
  parameter int SPI_DIVIDER_LEN = 16,
  parameter int SPI_SS_NB       = 8
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [4:0]           wb_adr_i,
  input  logic [31:0]          wb_dat_i,
  input  logic [3:0]           wb_sel_i,
  input  logic                 wb_we_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_cyc_i,
  output logic                 wb_ack_o,
  output logic                 wb_int_o,
  output logic [31:0]          wb_dat_o,
  output logic [SPI_SS_NB-1:0] ss_pad_o,
  output logic                 sclk_pad_o,
  output logic                 mosi_pad_o,
  input  logic                 miso_pad_i
);

  localparam int NWORDS = SPI_MAX_CHAR / 32;
  localparam int IDX_W  = $clog2(SPI_MAX_CHAR);
  localparam int CNT_W  = IDX_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [SPI_MAX_CHAR-1:0]    data;
  logic [IDX_W-1:0]           char_len;
  logic                       go, rx_neg, tx_neg, lsb, ie, ass;
  logic [SPI_DIVIDER_LEN-1:0] divider, cnt;
  logic [SPI_SS_NB-1:0]       ss;

  logic [CNT_W-1:0] len, rx_bits, tx_idx;
  logic [CNT_W:0]   toggles, last_cnt;
  logic [IDX_W-1:0] rx_pos, tx_pos, first_pos;
  logic             tick, tx_edge, rx_edge, last_toggle;
  logic             bus_req, wr_en;
  logic [31:0]      rd_mux;
  logic             unused_adr;

  // Bit position of the k-th transferred bit within the shared shift register.
  function automatic logic [IDX_W-1:0] bitpos(input logic [CNT_W-1:0] k,
                                              input logic [CNT_W-1:0] n,
                                              input logic lsb_first);
    return IDX_W'(lsb_first ? k : (n - k - CNT_W'(1)));
  endfunction

  assign unused_adr  = ^wb_adr_i[1:0];
  assign bus_req     = wb_cyc_i & wb_stb_i;
  assign wr_en       = bus_req & wb_ack_o & wb_we_i;

  assign len         = (char_len == '0) ? CNT_W'(SPI_MAX_CHAR) : {1'b0, char_len};
  assign last_cnt    = {len, 1'b0} - (CNT_W+1)'(1);
  assign tick        = (state == SHIFT) && (cnt == '0);
  assign tx_edge     = tick && (sclk_pad_o == tx_neg);
  assign rx_edge     = tick && (sclk_pad_o == rx_neg);
  assign last_toggle = tick && (toggles == last_cnt);

  // Drive the bit that will be sampled next; when both happen on the same
  // edge, the sample in flight consumes the current bit.
  assign tx_idx      = rx_bits + CNT_W'(rx_edge);
  assign rx_pos      = bitpos(rx_bits, len, lsb);
  assign tx_pos      = bitpos(tx_idx, len, lsb);
  assign first_pos   = bitpos('0, len, lsb);

  assign ss_pad_o    = ~(ss & (ass ? {SPI_SS_NB{go}} : {SPI_SS_NB{1'b1}}));

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (last_toggle) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cnt        <= '0;
      sclk_pad_o <= 1'b0;
      mosi_pad_o <= 1'b0;
      rx_bits    <= '0;
      toggles    <= '0;
    end else begin
      case (state)
        LOAD: begin
          cnt        <= divider;
          sclk_pad_o <= 1'b0;
          mosi_pad_o <= data[first_pos];
          rx_bits    <= '0;
          toggles    <= '0;
        end
        SHIFT: begin
          if (tick) begin
            cnt        <= divider;
            sclk_pad_o <= ~sclk_pad_o;
            toggles    <= toggles + (CNT_W+1)'(1);
          end else begin
            cnt <= cnt - SPI_DIVIDER_LEN'(1);
          end
          if (tx_edge && (tx_idx < len)) mosi_pad_o <= data[tx_pos];
          if (rx_edge) rx_bits <= rx_bits + CNT_W'(1);
        end
        default: sclk_pad_o <= 1'b0;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int w = 0; w < NWORDS; w++) begin
      if (wb_adr_i[4:2] == 3'(w)) rd_mux = data[32*w +: 32];
    end
    case (wb_adr_i[4:2])
      3'd4:    rd_mux = {18'b0, ass, ie, lsb, tx_neg, rx_neg, go, 1'b0, char_len};
      3'd5:    rd_mux = {{(32-SPI_DIVIDER_LEN){1'b0}}, divider};
      3'd6:    rd_mux = {{(32-SPI_SS_NB){1'b0}}, ss};
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      wb_int_o <= 1'b0;
      data     <= '0;
      char_len <= '0;
      go       <= 1'b0;
      rx_neg   <= 1'b0;
      tx_neg   <= 1'b0;
      lsb      <= 1'b0;
      ie       <= 1'b0;
      ass      <= 1'b0;
      divider  <= '0;
      ss       <= '0;
    end else begin
      wb_ack_o <= bus_req & ~wb_ack_o;
      if (bus_req & ~wb_ack_o) wb_dat_o <= rd_mux;
      if (bus_req & wb_ack_o)  wb_int_o <= 1'b0;
      if (last_toggle) begin
        go <= 1'b0;
        if (ie) wb_int_o <= 1'b1;
      end
      if (rx_edge) data[rx_pos] <= miso_pad_i;
      // Every register is frozen while a transfer is in flight.
      if (wr_en && !go) begin
        for (int w = 0; w < NWORDS; w++) begin
          for (int b = 0; b < 4; b++) begin
            if ((wb_adr_i[4:2] == 3'(w)) && wb_sel_i[b])
              data[32*w + 8*b +: 8] <= wb_dat_i[8*b +: 8];
          end
        end
        if (wb_adr_i[4:2] == 3'd4) begin
          if (wb_sel_i[0]) char_len <= wb_dat_i[IDX_W-1:0];
          if (wb_sel_i[1]) begin
            go     <= wb_dat_i[8];
            rx_neg <= wb_dat_i[9];
            tx_neg <= wb_dat_i[10];
            lsb    <= wb_dat_i[11];
            ie     <= wb_dat_i[12];
            ass    <= wb_dat_i[13];
          end
        end
        if (wb_adr_i[4:2] == 3'd5) begin
          for (int b = 0; b < SPI_DIVIDER_LEN/8; b++) begin
            if (wb_sel_i[b]) divider[8*b +: 8] <= wb_dat_i[8*b +: 8];
          end
        end
        if (wb_adr_i[4:2] == 3'd6) begin
          for (int b = 0; b < SPI_SS_NB/8; b++) begin
            if (wb_sel_i[b]) ss[8*b +: 8] <= wb_dat_i[8*b +: 8];
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_top_core.sv
`default_nettype none
// tb_spi_top_core - directed self-checking bench for spi_top_core.
module tb_spi_top_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  adr;
  logic [31:0] dat_i;
  logic [3:0]  sel;
  logic        we, stb, cyc;
  logic        ack, intr;
  logic [31:0] dat_o;
  logic [7:0]  ss;
  logic        sclk, mosi, miso, loop_en;

  int   checks = 0;
  int   errors = 0;
  int   lat;
  logic ack_after, int_at_ack, int_after;

  assign miso = loop_en & mosi;

  always #5 clk = ~clk;

  spi_top_core dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wb_adr_i   (adr),
    .wb_dat_i   (dat_i),
    .wb_sel_i   (sel),
    .wb_we_i    (we),
    .wb_stb_i   (stb),
    .wb_cyc_i   (cyc),
    .wb_ack_o   (ack),
    .wb_int_o   (intr),
    .wb_dat_o   (dat_o),
    .ss_pad_o   (ss),
    .sclk_pad_o (sclk),
    .mosi_pad_o (mosi),
    .miso_pad_i (miso)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus(input logic w, input logic [4:0] a, input logic [31:0] d,
                     output logic [31:0] r);
    int n;
    n = 0;
    adr = a; dat_i = d; sel = 4'hF; we = w; cyc = 1'b1; stb = 1'b1;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ack && n < 8);
    if (!ack) check("bus_ack", {31'b0, ack}, 32'd1);
    lat        = n;
    r          = dat_o;
    int_at_ack = intr;
    @(posedge clk); #1;
    ack_after = ack;
    int_after = intr;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    logic [31:0] dummy;
    bus(1'b1, a, d, dummy);
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] r);
    bus(1'b0, a, 32'h0, r);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Follows one transfer: mosi captured after each rising sclk, in time order.
  task automatic run_xfer(input int nbits, input int maxc, output logic [127:0] mb,
                          output int pmin, output int pmax, output int ss_bad,
                          output logic int_seen);
    int   rises, n, last_rise, per;
    logic prev;
    rises = 0; n = 0; last_rise = 0; pmin = 1 << 30; pmax = 0;
    ss_bad = 0; mb = '0; int_seen = 1'b0; prev = sclk;
    while (n < maxc) begin
      @(posedge clk); #1;
      n++;
      if (intr) int_seen = 1'b1;
      if (sclk && !prev) begin
        if (rises < 128) mb[rises] = mosi;
        if (ss[0] !== 1'b0) ss_bad++;
        if (rises > 0) begin
          per = n - last_rise;
          if (per < pmin) pmin = per;
          if (per > pmax) pmax = per;
        end
        last_rise = n;
        rises++;
      end
      if (!sclk && prev && rises == nbits) break;
      prev = sclk;
    end
    check("xfer_rises", rises, nbits);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    logic [31:0]  r;
    logic [127:0] mb;
    int           pmin, pmax, ssb, wait_n, hi;
    logic         iseen;

    rst = 1'b0; adr = '0; dat_i = '0; sel = '0; we = 1'b0; stb = 1'b0; cyc = 1'b0;
    loop_en = 1'b0;
    @(posedge clk); #1;
    pulse_reset();

    // Reset state
    check("rst_ss", {24'b0, ss}, 32'hFF);
    check("rst_sclk", {31'b0, sclk}, 32'd0);
    check("rst_mosi", {31'b0, mosi}, 32'd0);
    check("rst_int", {31'b0, intr}, 32'd0);
    check("rst_ack", {31'b0, ack}, 32'd0);
    check("rst_dat", dat_o, 32'd0);
    for (int i = 0; i < 7; i++) begin
      rd(5'(i * 4), r);
      check($sformatf("rst_reg%0d", i), r, 32'd0);
    end

    // Bus timing
    wr(5'h14, 32'h4);
    check("ack_latency", lat, 1);
    check("ack_one_cycle", {31'b0, ack_after}, 32'd0);
    rd(5'h14, r);
    check("div_readback", r, 32'h4);

    // Transfer A: 4 bits LSB first, TX_NEG, IE, ASS
    wr(5'h10, 32'h3C04);
    wr(5'h18, 32'h1);
    wr(5'h00, 32'h236F);
    wr(5'h10, 32'h3D04);
    run_xfer(4, 200, mb, pmin, pmax, ssb, iseen);
    check("a_mosi", mb[31:0], 32'hF);
    check("a_pmin", pmin, 10);
    check("a_pmax", pmax, 10);
    check("a_ss_busy", ssb, 0);
    check("a_ss_idle", {24'b0, ss}, 32'hFF);
    check("a_sclk_idle", {31'b0, sclk}, 32'd0);
    check("a_int_set", {31'b0, intr}, 32'd1);
    rd(5'h10, r);
    check("a_ctrl_done", r, 32'h3C04);
    check("int_at_ack", {31'b0, int_at_ack}, 32'd1);
    check("int_cleared", {31'b0, int_after}, 32'd0);
    rd(5'h00, r);
    check("a_rx0", r, 32'h2360);

    // Transfer B: loopback, 8 bits MSB first, IE=0
    loop_en = 1'b1;
    wr(5'h10, 32'h2408);
    wr(5'h00, 32'hA5);
    wr(5'h10, 32'h2508);
    run_xfer(8, 300, mb, pmin, pmax, ssb, iseen);
    check("b_mosi", mb[31:0], 32'hA5);
    check("b_ss_busy", ssb, 0);
    check("b_no_int", {31'b0, iseen}, 32'd0);
    rd(5'h00, r);
    check("b_rx0", r, 32'hA5);

    // Transfer C: busy protection
    wr(5'h00, 32'h3C);
    wr(5'h10, 32'h2508);
    wr(5'h00, 32'hFFFF_FFFF);
    wr(5'h14, 32'h0);
    wr(5'h18, 32'h80);
    wr(5'h10, 32'h0);
    rd(5'h10, r);
    check("c_ctrl_busy", r, 32'h2508);
    wait_n = 0;
    while (ss !== 8'hFF && wait_n < 300) begin
      @(posedge clk); #1;
      wait_n++;
    end
    check("c_done_ss", {24'b0, ss}, 32'hFF);
    rd(5'h10, r);
    check("c_ctrl_done", r, 32'h2408);
    rd(5'h00, r);
    check("c_rx0", r, 32'h3C);
    rd(5'h14, r);
    check("c_div_kept", r, 32'h4);
    rd(5'h18, r);
    check("c_ss_kept", r, 32'h1);

    // Transfer D: drive rising / sample falling, LSB first
    wr(5'h10, 32'h2A08);
    wr(5'h00, 32'hC1);
    wr(5'h10, 32'h2B08);
    run_xfer(8, 300, mb, pmin, pmax, ssb, iseen);
    check("d_mosi", mb[31:0], 32'hC1);
    check("d_no_int", {31'b0, iseen}, 32'd0);
    rd(5'h00, r);
    check("d_rx0", r, 32'hC1);

    // Transfer E: CHAR_LEN=0 (128 bits), DIVIDER=0
    wr(5'h10, 32'h3C00);
    wr(5'h14, 32'h0);
    wr(5'h00, 32'h0123_4567);
    wr(5'h04, 32'h89AB_CDEF);
    wr(5'h08, 32'hDEAD_BEEF);
    wr(5'h0C, 32'h0F1E_2D3C);
    wr(5'h10, 32'h3D00);
    run_xfer(128, 1000, mb, pmin, pmax, ssb, iseen);
    check("e_pmin", pmin, 2);
    check("e_pmax", pmax, 2);
    check("e_mosi0", mb[31:0], 32'h0123_4567);
    check("e_mosi3", mb[127:96], 32'h0F1E_2D3C);
    check("e_int", {31'b0, intr}, 32'd1);
    rd(5'h00, r); check("e_rx0", r, 32'h0123_4567);
    rd(5'h04, r); check("e_rx1", r, 32'h89AB_CDEF);
    rd(5'h08, r); check("e_rx2", r, 32'hDEAD_BEEF);
    rd(5'h0C, r); check("e_rx3", r, 32'h0F1E_2D3C);
    rd(5'h1C, r); check("e_unmapped", r, 32'h0);
    check("e_int_clr", {31'b0, intr}, 32'd0);

    // Reset mid-transfer
    wr(5'h14, 32'h4);
    wr(5'h10, 32'h2508);
    repeat (15) @(posedge clk);
    #1;
    pulse_reset();
    check("f_sclk", {31'b0, sclk}, 32'd0);
    check("f_ss", {24'b0, ss}, 32'hFF);
    check("f_mosi", {31'b0, mosi}, 32'd0);
    hi = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (sclk) hi++;
    end
    check("f_sclk_quiet", hi, 0);
    rd(5'h10, r); check("f_ctrl", r, 32'h0);
    rd(5'h14, r); check("f_div", r, 32'h0);
    rd(5'h00, r); check("f_rx0", r, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
